// File: rtl/if_id_stage.sv
// IF/ID pipeline register with valid/ready handshake, hazard stall and
// branch flush. A flushed or empty stage presents NOP_INSTR.
// Optional feature macro: IF_ID_SKID_EN -- adds a one-entry skid buffer so
// o_ready is a registered "skid empty" flag instead of a combinational path
// from i_ready/i_stall/i_flush.
module if_id_stage #(
  parameter int               NBITS     = 32,
  parameter logic [NBITS-1:0] NOP_INSTR = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [NBITS-1:0] i_pc,
  input  logic [NBITS-1:0] i_instruction,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [NBITS-1:0] o_pc,
  output logic [NBITS-1:0] o_instruction
);

  logic up_xfer;
  logic dn_xfer;

  // A stall blocks the downstream side even when the consumer is ready.
  assign dn_xfer = o_valid && i_ready && !i_stall;
  assign up_xfer = i_valid && o_ready;

`ifdef IF_ID_SKID_EN
  logic             skid_vld;
  logic [NBITS-1:0] skid_pc;
  logic [NBITS-1:0] skid_instr;

  // Ready depends only on local state, which cuts the ready path. Words
  // accepted during a stall land in the skid entry rather than being lost.
  assign o_ready = !skid_vld;

  // Output register refills from the skid first to preserve order; a new
  // word goes to the skid only when the output is full and not draining.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid       <= 1'b0;
      o_pc          <= '0;
      o_instruction <= NOP_INSTR;
      skid_vld      <= 1'b0;
      skid_pc       <= '0;
      skid_instr    <= '0;
    end else if (i_flush) begin
      o_valid       <= 1'b0;
      o_instruction <= NOP_INSTR;
      skid_vld      <= 1'b0;
    end else if (!o_valid || dn_xfer) begin
      if (skid_vld) begin
        o_valid       <= 1'b1;
        o_pc          <= skid_pc;
        o_instruction <= skid_instr;
        skid_vld      <= 1'b0;
      end else if (up_xfer) begin
        o_valid       <= 1'b1;
        o_pc          <= i_pc;
        o_instruction <= i_instruction;
      end else begin
        o_valid       <= 1'b0;
        o_instruction <= NOP_INSTR;
      end
    end else if (up_xfer) begin
      skid_vld   <= 1'b1;
      skid_pc    <= i_pc;
      skid_instr <= i_instruction;
    end
  end
`else
  // Accept only when the output slot is empty or draining this cycle.
  assign o_ready = !i_stall && !i_flush && (!o_valid || i_ready);

  // Single output register; o_pc keeps its last value when the stage empties.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid       <= 1'b0;
      o_pc          <= '0;
      o_instruction <= NOP_INSTR;
    end else if (i_flush) begin
      o_valid       <= 1'b0;
      o_instruction <= NOP_INSTR;
    end else if (up_xfer) begin
      o_valid       <= 1'b1;
      o_pc          <= i_pc;
      o_instruction <= i_instruction;
    end else if (dn_xfer) begin
      o_valid       <= 1'b0;
      o_instruction <= NOP_INSTR;
    end
  end
`endif

endmodule
